// File: rtl/sram_test_sequencer_if.sv
// Handshake bundle between the SRAM test sequencer (master) and the SRAM controller (slave).
interface sram_test_sequencer_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);
   logic              start_operation_output;
   logic              rw_output;
   logic [ADDR_W-1:0] address_output;
   logic [DATA_W-1:0] data_f2s_output;
   logic [DATA_W-1:0] data_s2f_input;
   logic              data_ready_signal_input;
   logic              writing_finished_signal_input;
   logic              busy_signal_input;

   modport master (
      output start_operation_output,
      output rw_output,
      output address_output,
      output data_f2s_output,
      input  data_s2f_input,
      input  data_ready_signal_input,
      input  writing_finished_signal_input,
      input  busy_signal_input
   );

   modport slave (
      input  start_operation_output,
      input  rw_output,
      input  address_output,
      input  data_f2s_output,
      output data_s2f_input,
      output data_ready_signal_input,
      output writing_finished_signal_input,
      output busy_signal_input
   );
endinterface

// File: rtl/sram_test_sequencer.sv
// Write-then-read-verify pass over [START_ADDR, END_ADDR] through the SRAM controller handshake.
// Optional build macro SRAM_TEST_STOP_ON_ERROR_EN: end the read pass at the first mismatch.
module sram_test_sequencer #(
   parameter int                ADDR_W      = 19,
   parameter int                DATA_W      = 8,
   parameter logic [ADDR_W-1:0] START_ADDR  = 19'h00000,
   parameter logic [ADDR_W-1:0] END_ADDR    = 19'h7FFFF,
   parameter int                TIMEOUT_CYC = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sram_test_sequencer_if.master ctrl,
   input  logic                  go_input,
   input  logic [1:0]            pattern_sel_input,
   output logic                  test_busy_output,
   output logic                  test_done_output,
   output logic                  test_pass_output,
   output logic                  timeout_error_output,
   output logic [15:0]           error_count_output,
   output logic [ADDR_W-1:0]     first_error_addr_output,
   output logic [DATA_W-1:0]     first_error_expected_output,
   output logic [DATA_W-1:0]     first_error_got_output
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_W_ISSUE = 3'd1;
   localparam logic [2:0] S_W_WAIT  = 3'd2;
   localparam logic [2:0] S_R_ISSUE = 3'd3;
   localparam logic [2:0] S_R_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [7:0]        LFSR_SEED = 8'h01;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
   localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT_CYC - 1);

   // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   function automatic logic [7:0] pattern_f(input logic [1:0] sel, input logic [7:0] a,
                                            input logic [7:0] lfsr);
      logic [7:0] p;
      case (sel)
         2'd0:    p = a;
         2'd1:    p = ~a;
         2'd2:    p = a[0] ? 8'hAA : 8'h55;
         2'd3:    p = lfsr;
         default: p = 8'h00;
      endcase
      return p;
   endfunction

   logic [2:0]        state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [7:0]        lfsr_r;
   logic [1:0]        sel_r;
   logic [15:0]       tmo_cnt_r;
   logic              start_r;
   logic              rw_r;
   logic [ADDR_W-1:0] address_r;
   logic [DATA_W-1:0] data_f2s_r;
   logic              test_busy_r;
   logic              test_done_r;
   logic              test_pass_r;
   logic              timeout_r;
   logic [15:0]       err_cnt_r;
   logic [ADDR_W-1:0] fe_addr_r;
   logic [DATA_W-1:0] fe_exp_r;
   logic [DATA_W-1:0] fe_got_r;

   logic [DATA_W-1:0] pattern_s;
   logic              mismatch_s;
   logic              last_s;
   logic [15:0]       err_inc_s;

   // Expected byte for the current address and the compare against returned read data
   always_comb begin
      pattern_s  = DATA_W'(pattern_f(sel_r, addr_r[7:0], lfsr_r));
      mismatch_s = (ctrl.data_s2f_input != pattern_s);
      last_s     = (addr_r == END_ADDR);
      err_inc_s  = (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
   end

   // Test sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         addr_r      <= ADDR_ZERO;
         lfsr_r      <= LFSR_SEED;
         sel_r       <= 2'd0;
         tmo_cnt_r   <= 16'd0;
         start_r     <= 1'b0;
         rw_r        <= 1'b0;
         address_r   <= ADDR_ZERO;
         data_f2s_r  <= DATA_ZERO;
         test_busy_r <= 1'b0;
         test_done_r <= 1'b0;
         test_pass_r <= 1'b0;
         timeout_r   <= 1'b0;
         err_cnt_r   <= 16'd0;
         fe_addr_r   <= ADDR_ZERO;
         fe_exp_r    <= DATA_ZERO;
         fe_got_r    <= DATA_ZERO;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               start_r <= 1'b0;
               if (go_input) begin
                  err_cnt_r   <= 16'd0;
                  fe_addr_r   <= ADDR_ZERO;
                  fe_exp_r    <= DATA_ZERO;
                  fe_got_r    <= DATA_ZERO;
                  timeout_r   <= 1'b0;
                  test_pass_r <= 1'b0;
                  sel_r       <= pattern_sel_input;
                  addr_r      <= START_ADDR;
                  lfsr_r      <= LFSR_SEED;
                  // An empty range finishes at once and reports fail
                  if (START_ADDR > END_ADDR) begin
                     state_r     <= S_DONE;
                     test_busy_r <= 1'b0;
                     test_done_r <= 1'b1;
                  end else begin
                     state_r     <= S_W_ISSUE;
                     test_busy_r <= 1'b1;
                     test_done_r <= 1'b0;
                  end
               end
            end
            S_W_ISSUE: begin
               if (!ctrl.busy_signal_input) begin
                  start_r    <= 1'b1;
                  rw_r       <= 1'b0;
                  address_r  <= addr_r;
                  data_f2s_r <= pattern_s;
                  tmo_cnt_r  <= 16'd0;
                  state_r    <= S_W_WAIT;
               end
            end
            S_W_WAIT: begin
               start_r <= 1'b0;
               if (ctrl.writing_finished_signal_input) begin
                  if (last_s) begin
                     addr_r  <= START_ADDR;
                     lfsr_r  <= LFSR_SEED;
                     state_r <= S_R_ISSUE;
                  end else begin
                     addr_r  <= addr_r + ADDR_ONE;
                     lfsr_r  <= lfsr_next(lfsr_r);
                     state_r <= S_W_ISSUE;
                  end
               end else if (tmo_cnt_r == TMO_LAST) begin
                  timeout_r   <= 1'b1;
                  test_busy_r <= 1'b0;
                  test_done_r <= 1'b1;
                  test_pass_r <= 1'b0;
                  state_r     <= S_DONE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 16'd1;
               end
            end
            S_R_ISSUE: begin
               if (!ctrl.busy_signal_input) begin
                  start_r   <= 1'b1;
                  rw_r      <= 1'b1;
                  address_r <= addr_r;
                  tmo_cnt_r <= 16'd0;
                  state_r   <= S_R_WAIT;
               end
            end
            S_R_WAIT: begin
               start_r <= 1'b0;
               if (ctrl.data_ready_signal_input) begin
`ifdef SRAM_TEST_STOP_ON_ERROR_EN
                  if (mismatch_s) begin
                     err_cnt_r   <= 16'd1;
                     fe_addr_r   <= addr_r;
                     fe_exp_r    <= pattern_s;
                     fe_got_r    <= ctrl.data_s2f_input;
                     test_busy_r <= 1'b0;
                     test_done_r <= 1'b1;
                     test_pass_r <= 1'b0;
                     state_r     <= S_DONE;
                  end else if (last_s) begin
                     test_busy_r <= 1'b0;
                     test_done_r <= 1'b1;
                     test_pass_r <= (err_cnt_r == 16'd0);
                     state_r     <= S_DONE;
                  end else begin
                     addr_r  <= addr_r + ADDR_ONE;
                     lfsr_r  <= lfsr_next(lfsr_r);
                     state_r <= S_R_ISSUE;
                  end
`else
                  if (mismatch_s) begin
                     err_cnt_r <= err_inc_s;
                     if (err_cnt_r == 16'd0) begin
                        fe_addr_r <= addr_r;
                        fe_exp_r  <= pattern_s;
                        fe_got_r  <= ctrl.data_s2f_input;
                     end
                  end
                  if (last_s) begin
                     test_busy_r <= 1'b0;
                     test_done_r <= 1'b1;
                     test_pass_r <= (err_cnt_r == 16'd0) && !mismatch_s;
                     state_r     <= S_DONE;
                  end else begin
                     addr_r  <= addr_r + ADDR_ONE;
                     lfsr_r  <= lfsr_next(lfsr_r);
                     state_r <= S_R_ISSUE;
                  end
`endif
               end else if (tmo_cnt_r == TMO_LAST) begin
                  timeout_r   <= 1'b1;
                  test_busy_r <= 1'b0;
                  test_done_r <= 1'b1;
                  test_pass_r <= 1'b0;
                  state_r     <= S_DONE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 16'd1;
               end
            end
            default: begin
               start_r <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign ctrl.start_operation_output  = start_r;
   assign ctrl.rw_output               = rw_r;
   assign ctrl.address_output          = address_r;
   assign ctrl.data_f2s_output         = data_f2s_r;
   assign test_busy_output             = test_busy_r;
   assign test_done_output             = test_done_r;
   assign test_pass_output             = test_pass_r;
   assign timeout_error_output         = timeout_r;
   assign error_count_output           = err_cnt_r;
   assign first_error_addr_output      = fe_addr_r;
   assign first_error_expected_output  = fe_exp_r;
   assign first_error_got_output       = fe_got_r;

endmodule

// File: doc/sram_test_sequencer.md
Name: sram_test_sequencer

Overview:
- Client-side initiator that drives the SRAM controller's user handshake (start/rw/address/data in; ready/finished/busy back) to run a full write-then-read-verify pass over an address range.
- Writes a selectable data pattern, reads every location back, compares against a regenerated pattern, and reports pass/fail, an error count and the first failing location.
- Sits between board-level start/LED/UART logic and the SRAM controller.

Parameters:
- ADDR_W, 19, address width (matches the 512K x 8 SRAM).
- DATA_W, 8, data width.
- START_ADDR, 0, first address tested.
- END_ADDR, 19'h7FFFF, last address tested (inclusive).
- TIMEOUT_CYC, 15, maximum cycles from a start pulse to the finished/ready pulse before aborting.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- go_input  in  1  begin a test run; sampled only in IDLE or DONE
- pattern_sel_input  in  2  pattern select, latched on go: 0=addr[7:0], 1=~addr[7:0], 2=checkerboard (addr[0] ? 8'hAA : 8'h55), 3=LFSR
- start_operation_output  out  1  one-cycle request to controller
- rw_output  out  1  1=read, 0=write
- address_output  out  ADDR_W  address to controller
- data_f2s_output  out  DATA_W  write data to controller
- data_s2f_input  in  DATA_W  read data from controller
- data_ready_signal_input  in  1  controller read-done pulse
- writing_finished_signal_input  in  1  controller write-done pulse
- busy_signal_input  in  1  controller busy
- test_busy_output  out  1  run in progress
- test_done_output  out  1  run finished (level)
- test_pass_output  out  1  valid when done: 1 = zero errors and no timeout
- timeout_error_output  out  1  controller failed to respond
- error_count_output  out  16  mismatches, saturating at 16'hFFFF
- first_error_addr_output  out  ADDR_W  address of first mismatch
- first_error_expected_output  out  DATA_W  expected byte at first mismatch
- first_error_got_output  out  DATA_W  read byte at first mismatch

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; every output 0; LFSR = 8'h01. Reset mid-run aborts immediately. Start is never re-issued after reset until a new go. Ready/finished pulses arriving outside W_WAIT/R_WAIT are ignored.
- States: IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, DONE.
- IDLE/DONE + go_input=1:
  - Clear error_count, first_error_*, timeout, done and pass.
  - Latch pattern_sel; addr = START_ADDR; LFSR = 8'h01; test_busy=1; go to W_ISSUE.
  - go_input while busy is ignored.
- START_ADDR > END_ADDR: the go goes straight to DONE with pass=0, error_count=0, no transactions issued.
- W_ISSUE:
  - Enter only when busy_signal_input=0, else hold.
  - Drive start_operation_output=1 for exactly one cycle with rw=0, address=addr, data_f2s=pattern(addr); go to W_WAIT.
- W_WAIT:
  - rw, address and data are held stable until the finished pulse.
  - On writing_finished_signal_input=1:
    - If addr==END_ADDR: addr=START_ADDR, LFSR=8'h01, go to R_ISSUE.
    - Else: addr+1, advance LFSR, go to W_ISSUE.
  - The controller is idle the cycle after the pulse, so back-to-back issue is legal.
- R_ISSUE: same rule as W_ISSUE with rw=1; go to R_WAIT.
- R_WAIT:
  - On data_ready_signal_input=1, compare data_s2f_input with pattern(addr) in that same cycle.
  - Mismatch: error_count+1 (saturating). If it is the first error, capture addr, expected and got.
  - Then either last address → DONE, or advance as in W_WAIT → R_ISSUE.
- Timeout:
  - Cycle counter clears on every start pulse.
  - If W_WAIT/R_WAIT lasts TIMEOUT_CYC cycles without the pulse: timeout_error=1, go to DONE.
- DONE: test_busy=0, test_done=1, test_pass = (error_count==0 && !timeout). Held until next go or reset.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'h01, one step per address.
  - Identical sequence on write and read passes.
  - pattern(addr) for sel=3 is the current LFSR value.
- Address increment: ADDR_W bits. END_ADDR=all-ones ends by the equality test, never by wrap.
- Each transaction costs 6 cycles; a full run = 2*(END-START+1)*6 cycles.

Optional Feature:
- Macro: SRAM_TEST_STOP_ON_ERROR_EN.
- Defined: the first mismatch in R_WAIT captures first_error_* and goes directly to DONE with error_count=1; remaining addresses are not read.
- Undefined: the read pass always completes and counts all errors.

Test Plan:
- START=0, END=3, sel=0, correct SRAM model → 4 writes of 00..03 then 4 reads; done=1, pass=1, error_count=0 after 48 cycles of transactions.
- START=0, END=3, sel=2, model byte at addr 2 stuck at 8'h00 → error_count=1, first_error_addr=2, expected=8'h55, got=8'h00, pass=0. With SRAM_TEST_STOP_ON_ERROR_EN: only 3 reads are issued.
- sel=3, END=7 → written bytes are 01,02,04,08,11,23,47,8E; read pass matches, pass=1.
- Controller never returns writing_finished → timeout_error=1 after 15 cycles in W_WAIT, done=1, pass=0.
- rst_n=0 while in R_WAIT → all outputs 0 next cycle, start stays low; a later go runs cleanly with pass=1.
- go held high during a run and START=5, END=4 → mid-run go ignored; the reversed range yields an immediate DONE with pass=0 and no start pulse.
